fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 80, meaning instruction memory size in bytes (multiple of 4).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, meaning first fetch byte address after reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mem_addr  output  32  byte address driven to instruction memory.
REQ-006 SHALL have port mem_req  output  1  mem_addr is a fetch whose word is expected on mem_rdata next cycle.
REQ-007 SHALL have port mem_rdata  input  32  memory word for the address issued the previous cycle.
REQ-008 SHALL have port instr  output  32  instruction word to decode.
REQ-009 SHALL have port instr_pc  output  32  byte address of instr.
REQ-010 SHALL have port instr_valid  output  1  instr/instr_pc valid.
REQ-011 SHALL have port instr_ready  input  1  decode accepts; transfer when valid and ready both high.
REQ-012 SHALL have port redirect  input  1  branch/jump redirect request.
REQ-013 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-014 SHALL have port done  output  1  fetch reached end of memory and buffer drained.
REQ-015 SHALL have port misalign  output  1  misaligned-redirect flag (see Configuration).

Function
REQ-016 SHALL implement FSM states BOOT, RUN, END; reset enters BOOT; BOOT->RUN after one cycle; RUN->END when pc > MEM_BYTES-4; END->RUN only on an accepted redirect.
REQ-017 SHALL drive mem_addr = pc always; mem_req = (state==RUN) and (pc <= MEM_BYTES-4) and (fifo_count + inflight - pop < 2) and not redirect.
REQ-018 SHALL increment pc by 4 on each cycle mem_req is high; inflight is set the cycle after mem_req.
REQ-019 SHALL write mem_rdata plus its address into a 2-entry FIFO the cycle after issue; first instr_valid two cycles after first mem_req.
REQ-020 SHALL sustain one instruction per cycle while instr_ready is held high.
REQ-021 SHALL present FIFO head on instr/instr_pc; instr_valid = FIFO not empty; held stable while valid and not ready.
REQ-022 SHALL never overflow the FIFO; a full FIFO with inflight data is impossible by REQ-017.
REQ-023 On redirect: flush FIFO, discard inflight word, pc <= redirect_pc, issue nothing that cycle; a valid/ready handshake in the same cycle SHALL count as not taken.
REQ-024 SHALL give redirect priority over stall, END state and simultaneous pop.
REQ-025 SHALL assert done = (state==END) and FIFO empty and no inflight.

Reset
REQ-026 SHALL on reset assertion immediately set pc=RESET_PC, state=BOOT, FIFO empty, inflight=0, outputs mem_req=0, instr_valid=0, instr=0, instr_pc=0, done=0, misalign=0; reset mid-fetch discards all buffered words.

Configuration
REQ-027 SHALL support macro FETCH_CTRL_MISALIGN_EN: defined -> redirect with redirect_pc[1:0]!=0 is ignored except misalign pulses high for one cycle, FIFO and pc untouched; undefined -> redirect_pc[1:0] forced to 0 and misalign tied 0.

Structure
REQ-028 SHALL place state enum, FIFO depth (2) and word size (4 bytes) constants in package fetch_pkg.
REQ-029 SHALL implement the buffer as sub-module fetch_fifo (2 entries, 64-bit payload, push/pop/flush, count).

Verification
REQ-030 Reset release, instr_ready=1, MEM_BYTES=80 -> instr_pc 0,4,...,76 on consecutive cycles, then done=1.
REQ-031 instr_ready=0 for 5 cycles from pc 8 -> at most 2 words buffered, mem_req low, instr_pc=8 held, no word lost on resume.
REQ-032 redirect to 0x20 while FIFO full and read inflight -> next valid instr_pc=0x20, no stale word emitted.
REQ-033 In END, redirect to 0x10 -> state RUN, done=0, instr_pc 0x10 onward.
REQ-034 Macro defined, redirect_pc=0x22 -> misalign one-cycle pulse, instruction stream continues unchanged.
REQ-035 reset asserted mid-stream with FIFO full -> instr_valid=0 immediately; refetch from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch controller.
//   fetch_state_t : controller FSM states (BOOT, RUN, END)
//   fetch_entry_t : 64-bit buffer payload {pc, word}
//   FIFO_DEPTH    : fetch buffer depth (2 entries)
//   WORD_BYTES    : instruction word size in bytes (4)
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned PTR_W      = 1;            // log2(FIFO_DEPTH)
  localparam int unsigned CNT_W      = 2;            // holds 0..FIFO_DEPTH
  localparam int unsigned OCC_W      = CNT_W + 1;    // count + inflight headroom

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_END  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } fetch_entry_t;

  // True when addr sits on an instruction-word boundary.
  function automatic logic word_aligned(input logic [XLEN-1:0] addr);
    return (addr & XLEN'(WORD_BYTES - 1)) == '0;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Two-entry buffer between the fetch stage and decode. Push and pop may happen
// in the same cycle; flush empties the buffer and wins over push/pop.
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   push_i, data_i    : write one {pc, word} entry
//   pop_i             : drop the head entry
//   flush_i           : discard all entries
//   head_o            : head entry (stable until popped)
//   count_o           : number of valid entries (0..2)
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  fetch_entry_t     data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     mem_q [FIFO_DEPTH];
  fetch_entry_t     mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i && (count_q != '0);
    // A full buffer still accepts a push when the head leaves the same cycle.
    do_push  = push_i && ((count_q != CNT_W'(FIFO_DEPTH)) || do_pop);

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Sequential instruction fetch from a one-cycle-latency instruction memory into
// a two-entry buffer feeding decode, with redirect (branch/jump) support.
// Build option:
//   FETCH_CTRL_MISALIGN_EN  defined   : a redirect whose target is not word
//                                       aligned is dropped and misalign pulses
//                                       high for one cycle.
//                           undefined : target low bits are forced to zero and
//                                       misalign is tied low.
// Parameters:
//   MEM_BYTES   : instruction memory size in bytes (multiple of 4)
//   RESET_PC    : first fetch address after reset
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   mem_addr, mem_req     : fetch address / fetch issued this cycle
//   mem_rdata             : word for the address issued the previous cycle
//   instr, instr_pc       : buffered instruction and its byte address
//   instr_valid/ready     : decode handshake
//   redirect, redirect_pc : change-of-flow request and target
//   done                  : end of memory reached and buffer drained
//   misalign              : misaligned-redirect pulse
// -----------------------------------------------------------------------------
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 80,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        done,
  output logic        misalign
);

  // Address of the last full word in memory.
  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - WORD_BYTES);

  fetch_state_t     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;

  logic             redir_take;
  logic [31:0]      redir_tgt;
  logic             pop;
  logic [OCC_W-1:0] occupancy;

  fetch_entry_t     fifo_in;
  fetch_entry_t     fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_push;

  // ---------------------------------------------------------------------------
  // Redirect qualification
  // ---------------------------------------------------------------------------
`ifdef FETCH_CTRL_MISALIGN_EN
  logic redir_bad;
  logic misalign_q;

  assign redir_bad  = redirect && !word_aligned(redirect_pc);
  assign redir_take = redirect && !redir_bad;
  assign redir_tgt  = redirect_pc;

  // One-cycle flag per dropped misaligned redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= redir_bad;
    end
  end

  assign misalign = misalign_q;
`else
  logic unused_redir_lo;

  assign redir_take      = redirect;
  assign redir_tgt       = {redirect_pc[31:2], 2'b00};
  assign unused_redir_lo = ^redirect_pc[1:0];
  assign misalign        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state, fetch issue and pc update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    pop           = 1'b0;
    occupancy     = '0;
    mem_req       = 1'b0;

    // A handshake coinciding with a redirect is not taken.
    pop       = instr_valid && instr_ready && !redir_take;
    // Entries that will be held once the in-flight word lands; issuing only
    // while this is below the depth guarantees the push always fits.
    occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);
    mem_req   = (state_q == S_RUN) && (pc_q <= LAST_PC) &&
                (occupancy < OCC_W'(FIFO_DEPTH)) && !redir_take;

    if (mem_req) begin
      pc_d          = pc_q + 32'(WORD_BYTES);
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end

    if (redir_take) begin
      pc_d    = redir_tgt;
      state_d = S_RUN;
    end else begin
      unique case (state_q)
        S_BOOT:  state_d = S_RUN;
        S_RUN:   if (pc_q > LAST_PC) state_d = S_END;
        S_END:   state_d = S_END;
        default: state_d = S_BOOT;
      endcase
    end
  end

  // State and fetch-tracking registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch buffer; a redirect drops the returning word and flushes the buffer
  // ---------------------------------------------------------------------------
  assign fifo_push = inflight_q && !redir_take;
  assign fifo_in   = '{pc: inflight_pc_q, word: mem_rdata};

  fetch_fifo u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .data_i  (fifo_in),
    .pop_i   (pop),
    .flush_i (redir_take),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_addr    = pc_q;
  assign instr       = fifo_head.word;
  assign instr_pc    = fifo_head.pc;
  assign instr_valid = (fifo_count != '0);
  assign done        = (state_q == S_END) && (fifo_count == '0) && !inflight_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Bench for fetch_ctrl. The reference model is the program-order rule: every
// accepted instruction carries the next expected address (starting at
// RESET_PC, +4 per accept, jumping to the target on a taken redirect) and the
// memory word for that address, and nothing past the last word is emitted.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam int unsigned MEM_BYTES = 80;
  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam logic [31:0] LAST_PC   = 32'(MEM_BYTES - 4);
  localparam logic [31:0] END_PC    = 32'(MEM_BYTES);

  logic        clk         = 1'b0;
  logic        reset       = 1'b1;
  logic        instr_ready = 1'b0;
  logic        redirect    = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] mem_rdata   = '0;
  logic [31:0] mem_addr, instr, instr_pc;
  logic        mem_req, instr_valid, done, misalign;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_pc  = '0;
  logic        redir_take;

  always #5 clk = ~clk;

  // Memory contents: a distinct word per address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // One-cycle-latency instruction memory.
  always @(posedge clk) mem_rdata <= word_of(mem_addr);

`ifdef FETCH_CTRL_MISALIGN_EN
  assign redir_take = redirect && (redirect_pc[1:0] == 2'b00);
`else
  assign redir_take = redirect;
`endif

  fetch_ctrl #(.MEM_BYTES(MEM_BYTES), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .done        (done),
    .misalign    (misalign)
  );

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; instr_ready = 1'b0; redirect = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0 || done !== 1'b0 || misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: req=%b valid=%b done=%b mis=%b, want all 0", mem_req, instr_valid, done, misalign);
    end
    n_tests++;
    if (instr !== 32'h0 || instr_pc !== 32'h0 || mem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_data: instr=%h pc=%h addr=%h, want 0/0/%h", instr, instr_pc, mem_addr, RESET_PC);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stream();
    int first_req = -1, first_val = -1, first_acc = -1, last_acc = -1, n_acc = 0;
    bit got_done = 0;
    reset = 1'b1; instr_ready = 1'b1; redirect = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    exp_pc = RESET_PC;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (mem_req && first_req < 0) first_req = c;
      if (instr_valid && first_val < 0) first_val = c;
      if (instr_valid && instr_ready && !redir_take) begin
        n_tests++;
        if (exp_pc > LAST_PC || instr_pc !== exp_pc || instr !== word_of(exp_pc)) begin
          n_fail++;
          $display("FAIL stream_seq: got pc=%h instr=%h, want pc=%h instr=%h", instr_pc, instr, exp_pc, word_of(exp_pc));
        end
        exp_pc += 32'd4;
        n_acc++;
        if (first_acc < 0) first_acc = c;
        last_acc = c;
      end
      if (done) begin got_done = 1; break; end
      @(posedge clk); #1;
    end
    n_tests++;
    if (first_val - first_req != 2) begin
      n_fail++;
      $display("FAIL stream_latency: first valid %0d cycles after first req, want 2", first_val - first_req);
    end
    n_tests++;
    if (n_acc != 20 || last_acc - first_acc != 19) begin
      n_fail++;
      $display("FAIL stream_rate: %0d accepts over %0d cycles, want 20 over 20", n_acc, last_acc - first_acc + 1);
    end
    n_tests++;
    if (!got_done || exp_pc !== END_PC) begin
      n_fail++;
      $display("FAIL stream_done: done=%b next_pc=%h, want 1/%h", got_done, exp_pc, END_PC);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_end_redirect();
    bit got_done = 0;
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL end_idle: done=%b, want 1", done);
    end
    redirect = 1'b1; redirect_pc = 32'h10;
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL end_redir_req: mem_req=%b, want 0", mem_req);
    end
    exp_pc = 32'h10;
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL end_resume: done=%b req=%b addr=%h, want 0/1/00000010", done, mem_req, mem_addr);
    end
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (instr_valid && instr_ready && !redir_take) begin
        n_tests++;
        if (exp_pc > LAST_PC || instr_pc !== exp_pc || instr !== word_of(exp_pc)) begin
          n_fail++;
          $display("FAIL end_seq: got pc=%h instr=%h, want pc=%h instr=%h", instr_pc, instr, exp_pc, word_of(exp_pc));
        end
        exp_pc += 32'd4;
      end
      if (done) begin got_done = 1; break; end
    end
    n_tests++;
    if (!got_done || exp_pc !== END_PC) begin
      n_fail++;
      $display("FAIL end_done: done=%b next_pc=%h, want 1/%h", got_done, exp_pc, END_PC);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stall();
    int  st = -1;
    bit  got_done = 0;
    reset = 1'b1; instr_ready = 1'b1; redirect = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    exp_pc = RESET_PC;
    for (int c = 0; c < 300; c++) begin
      if (st < 0 && instr_valid && instr_pc == 32'h8) st = c;
      instr_ready = !(st >= 0 && c < st + 5);
      @(negedge clk);
      if (st >= 0 && c < st + 5) begin
        n_tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h8 || mem_req !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%b pc=%h req=%b, want 1/00000008/0", instr_valid, instr_pc, mem_req);
        end
      end
      if (instr_valid && instr_ready && !redir_take) begin
        n_tests++;
        if (exp_pc > LAST_PC || instr_pc !== exp_pc || instr !== word_of(exp_pc)) begin
          n_fail++;
          $display("FAIL stall_seq: got pc=%h instr=%h, want pc=%h instr=%h", instr_pc, instr, exp_pc, word_of(exp_pc));
        end
        exp_pc += 32'd4;
      end
      if (done) begin got_done = 1; break; end
      @(posedge clk); #1;
    end
    n_tests++;
    if (!got_done || st < 0 || exp_pc !== END_PC) begin
      n_fail++;
      $display("FAIL stall_done: done=%b stalled=%0d next_pc=%h, want 1/yes/%h", got_done, st >= 0, exp_pc, END_PC);
    end
    instr_ready = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_redirect_full();
    int st = -1;
    bit got_done = 0;
    reset = 1'b1; instr_ready = 1'b1; redirect = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    exp_pc = RESET_PC;
    for (int c = 0; c < 300; c++) begin
      if (st < 0 && instr_valid && instr_pc == 32'h8) st = c;
      instr_ready = !(st >= 0 && c < st + 2);
      redirect    = (st >= 0 && c == st + 2);
      redirect_pc = 32'h20;
      @(negedge clk);
      if (redir_take) begin
        n_tests++;
        if (mem_req !== 1'b0 || instr_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL redir_cycle: req=%b valid=%b, want 0/1", mem_req, instr_valid);
        end
        exp_pc = 32'h20;
      end else if (instr_valid && instr_ready) begin
        n_tests++;
        if (exp_pc > LAST_PC || instr_pc !== exp_pc || instr !== word_of(exp_pc)) begin
          n_fail++;
          $display("FAIL redir_seq: got pc=%h instr=%h, want pc=%h instr=%h", instr_pc, instr, exp_pc, word_of(exp_pc));
        end
        exp_pc += 32'd4;
      end
      if (done) begin got_done = 1; break; end
      @(posedge clk); #1;
    end
    redirect = 1'b0;
    n_tests++;
    if (!got_done || st < 0 || exp_pc !== END_PC) begin
      n_fail++;
      $display("FAIL redir_done: done=%b next_pc=%h, want 1/%h", got_done, exp_pc, END_PC);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_misalign();
    bit got_done = 0;
    reset = 1'b1; instr_ready = 1'b1; redirect = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    exp_pc = RESET_PC;
    for (int c = 0; c < 300; c++) begin
      redirect    = (c == 6);
      redirect_pc = 32'h22;
      @(negedge clk);
      if (c == 7 || c == 8) begin
        n_tests++;
`ifdef FETCH_CTRL_MISALIGN_EN
        if (misalign !== (c == 7)) begin
          n_fail++;
          $display("FAIL misalign_pulse: cycle %0d misalign=%b, want %b", c, misalign, c == 7);
        end
`else
        if (misalign !== 1'b0) begin
          n_fail++;
          $display("FAIL misalign_tied: cycle %0d misalign=%b, want 0", c, misalign);
        end
`endif
      end
      if (redir_take) begin
        exp_pc = redirect_pc & ~32'h3;
      end else if (instr_valid && instr_ready) begin
        n_tests++;
        if (exp_pc > LAST_PC || instr_pc !== exp_pc || instr !== word_of(exp_pc)) begin
          n_fail++;
          $display("FAIL misalign_seq: got pc=%h instr=%h, want pc=%h instr=%h", instr_pc, instr, exp_pc, word_of(exp_pc));
        end
        exp_pc += 32'd4;
      end
      if (done) begin got_done = 1; break; end
      @(posedge clk); #1;
    end
    redirect = 1'b0;
    n_tests++;
    if (!got_done || exp_pc !== END_PC) begin
      n_fail++;
      $display("FAIL misalign_done: done=%b next_pc=%h, want 1/%h", got_done, exp_pc, END_PC);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    int st = -1;
    bit got_done = 0;
    reset = 1'b1; instr_ready = 1'b1; redirect = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    for (int c = 0; c < 100 && st < 0; c++) begin
      if (instr_valid && instr_pc == 32'h10) st = c;
      else begin @(posedge clk); #1; end
    end
    instr_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_tests++;
    if (st < 0 || instr_valid !== 1'b1 || instr_pc !== 32'h10) begin
      n_fail++;
      $display("FAIL rstmid_pre: valid=%b pc=%h, want 1/00000010", instr_valid, instr_pc);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0 || instr !== 32'h0 ||
        instr_pc !== 32'h0 || mem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL rstmid_async: valid=%b req=%b done=%b instr=%h pc=%h addr=%h, want 0/0/0/0/0/%h",
               instr_valid, mem_req, done, instr, instr_pc, mem_addr, RESET_PC);
    end
    @(posedge clk); #1 reset = 1'b0; instr_ready = 1'b1;
    exp_pc = RESET_PC;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (instr_valid && instr_ready && !redir_take) begin
        n_tests++;
        if (exp_pc > LAST_PC || instr_pc !== exp_pc || instr !== word_of(exp_pc)) begin
          n_fail++;
          $display("FAIL rstmid_seq: got pc=%h instr=%h, want pc=%h instr=%h", instr_pc, instr, exp_pc, word_of(exp_pc));
        end
        exp_pc += 32'd4;
      end
      if (done) begin got_done = 1; break; end
      @(posedge clk); #1;
    end
    n_tests++;
    if (!got_done || exp_pc !== END_PC) begin
      n_fail++;
      $display("FAIL rstmid_done: done=%b next_pc=%h, want 1/%h", got_done, exp_pc, END_PC);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    bit got_done = 0;
    reset = 1'b1; instr_ready = 1'b1; redirect = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    exp_pc = RESET_PC;
    for (int c = 0; c < 1200; c++) begin
      if (c < 1000) begin
        instr_ready = ($urandom % 4) != 0;
        redirect    = ($urandom % 12) == 0;
        redirect_pc = 32'($urandom_range(0, 23) * 4);
        if (($urandom % 4) == 0) redirect_pc = redirect_pc | 32'($urandom % 4);
      end else begin
        instr_ready = 1'b1;
        redirect    = 1'b0;
      end
      @(negedge clk);
      if (mem_req) begin
        n_tests++;
        if (mem_addr > LAST_PC) begin
          n_fail++;
          $display("FAIL rand_range: fetch at %h, want <= %h", mem_addr, LAST_PC);
        end
      end
      if (redir_take) begin
        n_tests++;
        if (mem_req !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_redir_req: mem_req=%b during redirect, want 0", mem_req);
        end
        exp_pc = redirect_pc & ~32'h3;
      end else if (instr_valid && instr_ready) begin
        n_tests++;
        if (exp_pc > LAST_PC || instr_pc !== exp_pc || instr !== word_of(exp_pc)) begin
          n_fail++;
          $display("FAIL rand_seq: cycle %0d got pc=%h instr=%h, want pc=%h instr=%h",
                   c, instr_pc, instr, exp_pc, word_of(exp_pc));
        end
        exp_pc += 32'd4;
      end
      if (c >= 1000 && done) begin got_done = 1; break; end
      @(posedge clk); #1;
    end
    n_tests++;
    if (!got_done || exp_pc <= LAST_PC) begin
      n_fail++;
      $display("FAIL rand_done: done=%b next_pc=%h, want 1 and past %h", got_done, exp_pc, LAST_PC);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_stream();
    test_end_redirect();
    test_stall();
    test_redirect_full();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
